// File: rtl/apb_requester.sv
// APB3 initiator: turns a valid/ready command into one SETUP/ACCESS transfer,
// with wait-state support, PSLVERR reporting and a programmable stall timeout.
module apb_requester #(
  parameter int unsigned ADDR_W         = 6,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              apb_psel_o,
  output logic              apb_penable_o,
  output logic              apb_pwrite_o,
  output logic [ADDR_W-1:0] apb_paddr_o,
  output logic [DATA_W-1:0] apb_pwdata_o,
  input  logic [DATA_W-1:0] apb_prdata_i,
  input  logic              apb_pready_i,
  input  logic              apb_pslverr_i
);

  localparam int unsigned CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam int unsigned LAST_INT   = TIMEOUT_EN ? (TIMEOUT_CYCLES - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_INT);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                cmd_ready, cmd_ready_nxt;
  logic                psel, psel_nxt;
  logic                penable, penable_nxt;
  logic                pwrite, pwrite_nxt;
  logic [ADDR_W-1:0]   paddr, paddr_nxt;
  logic [DATA_W-1:0]   pwdata, pwdata_nxt;
  logic                rsp_valid, rsp_valid_nxt;
  logic [DATA_W-1:0]   rsp_rdata, rsp_rdata_nxt;
  logic                rsp_err, rsp_err_nxt;
  logic                rsp_timeout, rsp_timeout_nxt;

  // Next-state and next-output logic; every output register is loaded from here.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    cmd_ready_nxt   = cmd_ready;
    psel_nxt        = psel;
    penable_nxt     = penable;
    pwrite_nxt      = pwrite;
    paddr_nxt       = paddr;
    pwdata_nxt      = pwdata;
    rsp_valid_nxt   = 1'b0;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_err_nxt     = rsp_err;
    rsp_timeout_nxt = rsp_timeout;

    case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          state_nxt     = SETUP;
          cmd_ready_nxt = 1'b0;
          psel_nxt      = 1'b1;
          pwrite_nxt    = cmd_write_i;
          paddr_nxt     = cmd_addr_i;
          pwdata_nxt    = cmd_wdata_i;
        end else begin
          cmd_ready_nxt = 1'b1;
        end
      end
      SETUP: begin
        state_nxt   = ACCESS;
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
      end
      ACCESS: begin
        // PREADY wins over a timeout that falls in the same cycle.
        if (apb_pready_i) begin
          state_nxt       = IDLE;
          cmd_ready_nxt   = 1'b1;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = apb_pslverr_i;
          rsp_timeout_nxt = 1'b0;
          rsp_rdata_nxt   = (!pwrite && !apb_pslverr_i) ? apb_prdata_i : '0;
        end else if (TIMEOUT_EN && (cnt == CNT_LAST)) begin
          state_nxt       = IDLE;
          cmd_ready_nxt   = 1'b1;
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_valid_nxt   = 1'b1;
          rsp_err_nxt     = 1'b1;
          rsp_timeout_nxt = 1'b1;
          rsp_rdata_nxt   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end else begin
          cnt_nxt = cnt;
        end
      end
      default: begin
        state_nxt     = IDLE;
        cmd_ready_nxt = 1'b1;
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;
      end
    endcase
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state       <= IDLE;
      cnt         <= '0;
      cmd_ready   <= 1'b1;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      cmd_ready   <= cmd_ready_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      pwrite      <= pwrite_nxt;
      paddr       <= paddr_nxt;
      pwdata      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_err     <= rsp_err_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

  assign cmd_ready_o   = cmd_ready;
  assign apb_psel_o    = psel;
  assign apb_penable_o = penable;
  assign apb_pwrite_o  = pwrite;
  assign apb_paddr_o   = paddr;
  assign apb_pwdata_o  = pwdata;
  assign rsp_valid_o   = rsp_valid;
  assign rsp_rdata_o   = rsp_rdata;
  assign rsp_err_o     = rsp_err;
  assign rsp_timeout_o = rsp_timeout;

endmodule

// File: tb/tb_apb_requester.sv
// Bench for apb_requester: vector table plus hand sequences, with a response
// scoreboard checked by a monitor on every rsp_valid pulse.
module tb_apb_requester;
  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o, rsp_err_o, rsp_timeout_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          apb_psel_o, apb_penable_o, apb_pwrite_o;
  logic [AW-1:0] apb_paddr_o;
  logic [DW-1:0] apb_pwdata_o, apb_prdata_i;
  logic          apb_pready_i, apb_pslverr_i;

  apb_requester #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_timeout_o(rsp_timeout_o),
    .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o), .apb_pwrite_o(apb_pwrite_o),
    .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o), .apb_prdata_i(apb_prdata_i),
    .apb_pready_i(apb_pready_i), .apb_pslverr_i(apb_pslverr_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            waits;
    logic          slverr;
    logic [DW-1:0] prdata;
    logic [DW-1:0] exp_rdata;
    logic          exp_err;
    logic          exp_to;
    int            exp_acc;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
  } rsp_t;

  rsp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid_o === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata_o, e.rdata);
        check("rsp_err", {31'd0, rsp_err_o}, {31'd0, e.err});
        check("rsp_timeout", {31'd0, rsp_timeout_o}, {31'd0, e.to});
      end
    end
  end

  task automatic idle_bus();
    // Completer noise outside ACCESS must be ignored.
    apb_pready_i  = 1'b1;
    apb_pslverr_i = 1'b1;
    apb_prdata_i  = $urandom;
  endtask

  task automatic run_vec(input vec_t v);
    int acc;
    rsp_t e;
    check("idle_ready", {31'd0, cmd_ready_o}, 32'd1);
    cmd_valid_i = 1'b1;
    cmd_write_i = v.write;
    cmd_addr_i  = v.addr;
    cmd_wdata_i = v.wdata;
    e.rdata = v.exp_rdata; e.err = v.exp_err; e.to = v.exp_to;
    sb.push_back(e);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    cmd_wdata_i = $urandom;
    check("setup_psel", {31'd0, apb_psel_o}, 32'd1);
    check("setup_penable", {31'd0, apb_penable_o}, 32'd0);
    check("setup_ready", {31'd0, cmd_ready_o}, 32'd0);
    check("setup_paddr", {26'd0, apb_paddr_o}, {26'd0, v.addr});
    check("setup_pwrite", {31'd0, apb_pwrite_o}, {31'd0, v.write});
    check("setup_pwdata", apb_pwdata_o, v.wdata);
    acc = 0;
    @(negedge clk);
    while (apb_psel_o && apb_penable_o && acc < 12) begin
      check("access_paddr", {26'd0, apb_paddr_o}, {26'd0, v.addr});
      check("access_pwdata", apb_pwdata_o, v.wdata);
      apb_pready_i  = (acc == v.waits);
      apb_pslverr_i = (acc == v.waits) ? v.slverr : 1'b0;
      apb_prdata_i  = (acc == v.waits) ? v.prdata : 32'($urandom);
      acc++;
      @(negedge clk);
      idle_bus();
    end
    check("access_cycles", acc, v.exp_acc);
    check("done_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    check("done_psel", {31'd0, apb_psel_o}, 32'd0);
    check("done_ready", {31'd0, cmd_ready_o}, 32'd1);
    @(negedge clk);
    check("pulse_width", {31'd0, rsp_valid_o}, 32'd0);
    check("rdata_hold", rsp_rdata_o, v.exp_rdata);
    check("err_hold", {31'd0, rsp_err_o}, {31'd0, v.exp_err});
  endtask

  vec_t vecs[8];
  vec_t recov;
  vec_t b2b[3];
  rsp_t b2b_exp[3];
  int   acc_at[3];

  initial begin
    // write, addr, wdata, waits, slverr, prdata, exp_rdata, exp_err, exp_to, exp_acc
    vecs[0] = '{1'b1, 6'h04, 32'hDEADBEEF, 0,  1'b0, 32'h77777777, 32'h0,        1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 6'h00, 32'h0,        1,  1'b0, 32'hADD00000, 32'hADD00000, 1'b0, 1'b0, 2};
    vecs[2] = '{1'b0, 6'h08, 32'h0,        0,  1'b1, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0, 1};
    vecs[3] = '{1'b0, 6'h10, 32'h0,        15, 1'b0, 32'h12345678, 32'h0,        1'b1, 1'b1, 4};
    vecs[4] = '{1'b1, 6'h0C, 32'h000000A5, 0,  1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 1};
    vecs[5] = '{1'b0, 6'h3F, 32'h0,        3,  1'b0, 32'h5A5A5A5A, 32'h5A5A5A5A, 1'b0, 1'b0, 4};
    vecs[6] = '{1'b0, 6'h14, 32'h0,        0,  1'b0, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 1'b0, 1};
    vecs[7] = '{1'b1, 6'h20, 32'hCAFE0001, 2,  1'b1, 32'h99999999, 32'h0,        1'b1, 1'b0, 3};
    recov   = '{1'b0, 6'h18, 32'h0,        0,  1'b0, 32'h600DD00D, 32'h600DD00D, 1'b0, 1'b0, 1};
    b2b[0]  = '{1'b1, 6'h01, 32'h11111111, 0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 1};
    b2b[1]  = '{1'b0, 6'h02, 32'h0,        0, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1};
    b2b[2]  = '{1'b1, 6'h03, 32'h33333333, 0, 1'b0, 32'h0, 32'h0,        1'b0, 1'b0, 1};

    reset_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
    idle_bus();
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("rst_psel", {31'd0, apb_psel_o}, 32'd0);
    check("rst_penable", {31'd0, apb_penable_o}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("rst_rdata", rsp_rdata_o, 32'd0);
    reset_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset during a stalled ACCESS: bus drops, no response, err cleared.
    apb_pready_i = 1'b0; apb_pslverr_i = 1'b0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 6'h2A;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_access", {30'd0, apb_psel_o, apb_penable_o}, 32'd3);
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    check("midrst_psel", {31'd0, apb_psel_o}, 32'd0);
    check("midrst_penable", {31'd0, apb_penable_o}, 32'd0);
    check("midrst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    check("midrst_ready", {31'd0, cmd_ready_o}, 32'd1);
    check("midrst_err", {31'd0, rsp_err_o}, 32'd0);
    repeat (6) @(negedge clk);
    idle_bus();
    run_vec(recov);

    // Back-to-back commands with cmd_valid held high and a zero-wait completer.
    apb_pready_i = 1'b1; apb_pslverr_i = 1'b0; apb_prdata_i = 32'hCAFEF00D;
    for (int k = 0; k < 3; k++) begin
      b2b_exp[k].rdata = b2b[k].exp_rdata; b2b_exp[k].err = 1'b0; b2b_exp[k].to = 1'b0;
      acc_at[k] = -1;
    end
    begin
      int idx;
      bit took;
      idx = 0;
      cmd_valid_i = 1'b1; cmd_write_i = b2b[0].write; cmd_addr_i = b2b[0].addr; cmd_wdata_i = b2b[0].wdata;
      for (int c = 0; c < 10; c++) begin
        check("b2b_ready", {31'd0, cmd_ready_o}, {31'd0, (c % 3 == 0)});
        took = 1'b0;
        if (cmd_valid_i && cmd_ready_o && idx < 3) begin
          acc_at[idx] = c;
          sb.push_back(b2b_exp[idx]);
          took = 1'b1;
        end
        @(negedge clk);
        if (took) begin
          idx++;
          if (idx < 3) begin
            cmd_write_i = b2b[idx].write; cmd_addr_i = b2b[idx].addr; cmd_wdata_i = b2b[idx].wdata;
          end else begin
            cmd_valid_i = 1'b0;
          end
        end
      end
    end
    check("b2b_accept0", acc_at[0], 32'd0);
    check("b2b_accept1", acc_at[1], 32'd3);
    check("b2b_accept2", acc_at[2], 32'd6);

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
APB initiator that turns a simple valid/ready command interface into APB3 transfers toward on-chip completers, such as the WS2812 LED controller's register block. The block runs one transfer at a time (SETUP then ACCESS), supports completer wait states and PSLVERR, and aborts a stalled transfer after a programmable timeout. It sits between a command source (debug bridge or sequencer) and the APB completer.

Parameters:
ADDR_W, 6, APB address width in bits.
DATA_W, 32, APB data width in bits.
TIMEOUT_CYCLES, 256, number of ACCESS cycles without PREADY before abort; 0 disables the timeout.

Ports:
clk_i  in  1  system clock, all logic on rising edge
reset_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o
cmd_write_i  in  1  1 = write, 0 = read
cmd_addr_i  in  ADDR_W  transfer address
cmd_wdata_i  in  DATA_W  write data
rsp_valid_o  out  1  one-cycle pulse, transfer finished
rsp_rdata_o  out  DATA_W  read data (0 for writes, errors and timeouts)
rsp_err_o  out  1  PSLVERR seen or timeout
rsp_timeout_o  out  1  transfer aborted by timeout
apb_psel_o  out  1  APB select
apb_penable_o  out  1  APB enable
apb_pwrite_o  out  1  APB direction
apb_paddr_o  out  ADDR_W  APB address
apb_pwdata_o  out  DATA_W  APB write data
apb_prdata_i  in  DATA_W  APB read data
apb_pready_i  in  1  completer ready
apb_pslverr_i  in  1  completer error

Behaviour:
- Reset (reset_i=1 at a clock edge): state IDLE. All outputs are 0 except cmd_ready_o=1. The timeout counter clears. Reset in any state aborts the transfer on the next edge, and no rsp_valid_o is issued for the aborted transfer.
- States: IDLE, SETUP, ACCESS. All APB and rsp outputs are registered.
- IDLE: cmd_ready_o=1, psel=0, penable=0. On cmd_valid_i=1:
  - Latch write, addr and wdata into apb_pwrite_o, apb_paddr_o and apb_pwdata_o.
  - Move to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, cmd_ready_o=0. Move to ACCESS and clear the counter.
- ACCESS: psel=1, penable=1. paddr, pwrite and pwdata stay stable for the whole transfer.
  - apb_pready_i=1 completes the transfer:
    - rsp_valid_o=1 on the next cycle.
    - rsp_err_o=apb_pslverr_i.
    - rsp_rdata_o=apb_prdata_i for reads when pslverr=0, otherwise 0.
    - rsp_timeout_o=0.
    - psel and penable go to 0, and the state returns to IDLE.
  - apb_pready_i=0 increments the counter. If TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 while pready is still 0:
    - Abort: psel and penable go to 0.
    - rsp_valid_o=1, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0.
    - Return to IDLE.
  - PREADY arriving in the same cycle as the timeout threshold counts as normal completion.
- Latency: with a zero-wait completer, acceptance is at cycle N. SETUP is N+1, ACCESS is N+2, and rsp_valid_o plus cmd_ready_o=1 are at N+3. The minimum back-to-back command interval is 3 cycles.
- rsp_valid_o is high for exactly one cycle and needs no acknowledge. rsp_rdata_o, rsp_err_o and rsp_timeout_o hold their values until the next response.
- pready and pslverr are ignored outside ACCESS. cmd_valid_i is ignored while cmd_ready_o=0.
- The counter width is enough to hold TIMEOUT_CYCLES, and the counter does not wrap.

Test Plan:
- Zero-wait write: cmd write addr 0x04, wdata 0xDEADBEEF; completer pready=1 in the first ACCESS cycle -> psel high 2 cycles, penable high 1 cycle, paddr=0x04, pwdata=0xDEADBEEF, rsp_valid 3 cycles after accept, err=0.
- Read with 1 wait state: read addr 0x00; completer returns 0xADD00000 with pready on the 2nd ACCESS cycle -> rsp_rdata=0xADD00000, err=0, rsp_valid 4 cycles after accept, paddr stable throughout.
- Slave error: read addr 0x08; completer pready=1 and pslverr=1 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0.
- Timeout: TIMEOUT_CYCLES=4 and pready held at 0 -> psel/penable drop after 4 ACCESS cycles, rsp_valid with err=1, timeout=1; the next command is then accepted normally.
- Back-to-back: cmd_valid held high with 3 queued commands to zero-wait completer -> accepts at cycles 0, 3 and 6; cmd_ready_o low in SETUP/ACCESS; 3 rsp pulses in order.
- Reset mid-ACCESS: assert reset_i during a wait-stated transfer -> next cycle psel=0, penable=0, rsp_valid=0, cmd_ready=1; no spurious response afterwards.
